// File: rtl/msk_inv_mixcolumns_col_pkg.sv
// Shared definitions for the masked InvMixColumns column engine:
// GF(2^8) constants, FSM encoding and share-layout / field helpers.
package msk_inv_mixcolumns_col_pkg;

    localparam logic [7:0] AES_RED_POLY = 8'h1b;

    // InvMixColumns row coefficients, applied to a_k, a_{k+1}, a_{k+2}, a_{k+3}
    localparam logic [7:0] IMC_C0 = 8'h0e;
    localparam logic [7:0] IMC_C1 = 8'h0b;
    localparam logic [7:0] IMC_C2 = 8'h0d;
    localparam logic [7:0] IMC_C3 = 8'h09;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } imc_state_e;

    // Bit i of share j inside a masked byte of n_sh shares
    function automatic int unsigned sh_idx(input int unsigned bit_i,
                                           input int unsigned share_j,
                                           input int unsigned n_sh);
        return bit_i * n_sh + share_j;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_RED_POLY : 8'h00);
    endfunction

    // Multiply by a coefficient < 0x10 using precomputed x, 2x, 4x, 8x
    function automatic logic [7:0] mul_small(input logic [3:0] c,
                                             input logic [7:0] x1,
                                             input logic [7:0] x2,
                                             input logic [7:0] x4,
                                             input logic [7:0] x8);
        return (c[0] ? x1 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/msk_inv_mixcolumns_col_if.sv
// Column handshake bus for the masked InvMixColumns engine.
interface msk_inv_mixcolumns_col_if #(
    parameter int unsigned d = 2
);
    logic              in_valid;
    logic              in_ready;
    logic              bypass;
    logic [32*d-1:0]   sh_col_in;
    logic              out_valid;
    logic              out_ready;
    logic [32*d-1:0]   sh_col_out;

    modport master (
        output in_valid, bypass, sh_col_in, out_ready,
        input  in_ready, out_valid, sh_col_out
    );

    modport slave (
        input  in_valid, bypass, sh_col_in, out_ready,
        output in_ready, out_valid, sh_col_out
    );
endinterface

// File: rtl/msk_inv_mc_coeffs.sv
// Sharewise GF(2^8) products 09*x, 0b*x, 0d*x, 0e*x of one masked byte.
// Each share has its own xtime chain; no signal mixes two shares.
module msk_inv_mc_coeffs
    import msk_inv_mixcolumns_col_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic [8*d-1:0] x_i,
    output logic [8*d-1:0] m9_o,
    output logic [8*d-1:0] mb_o,
    output logic [8*d-1:0] md_o,
    output logic [8*d-1:0] me_o
);

    for (genvar j = 0; j < d; j++) begin : g_share
        logic [7:0] a, x2, x4, x8;
        logic [7:0] p9, pb, pd, pe;

        assign x2 = xtime(a);
        assign x4 = xtime(x2);
        assign x8 = xtime(x4);

        assign pe = mul_small(IMC_C0[3:0], a, x2, x4, x8);
        assign pb = mul_small(IMC_C1[3:0], a, x2, x4, x8);
        assign pd = mul_small(IMC_C2[3:0], a, x2, x4, x8);
        assign p9 = mul_small(IMC_C3[3:0], a, x2, x4, x8);

        for (genvar i = 0; i < 8; i++) begin : g_bit
            assign a[i]                  = x_i[sh_idx(i, j, d)];
            assign m9_o[sh_idx(i, j, d)] = p9[i];
            assign mb_o[sh_idx(i, j, d)] = pb[i];
            assign md_o[sh_idx(i, j, d)] = pd[i];
            assign me_o[sh_idx(i, j, d)] = pe[i];
        end
    end

endmodule

// File: rtl/msk_inv_mixcolumns_col.sv
// Masked iterative InvMixColumns on one state column: one result byte per
// cycle, column rotated down each cycle so the same four multipliers serve
// every output row. Bypass returns the captured column unchanged.
module msk_inv_mixcolumns_col
    import msk_inv_mixcolumns_col_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    msk_inv_mixcolumns_col_if.slave       bus
);

    localparam int unsigned BW = 8 * d;
    localparam int unsigned CW = 32 * d;

    imc_state_e      state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   res_q, res_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            byp_q, byp_d;

    logic            in_ready_w;
    logic            out_valid_w;
    logic            load_w;

    // prod_w[row][k]: product of col_q row 'row' with coefficient k (0e,0b,0d,09)
    logic [BW-1:0]   prod_w [4][4];
    logic [BW-1:0]   byte_w;

    for (genvar r = 0; r < 4; r++) begin : g_row
        msk_inv_mc_coeffs #(.d(d)) u_coeffs (
            .x_i  (col_q[r*BW +: BW]),
            .me_o (prod_w[r][0]),
            .mb_o (prod_w[r][1]),
            .md_o (prod_w[r][2]),
            .m9_o (prod_w[r][3])
        );
    end

    // Row 0 of the rotated column is always a_k, so the diagonal gives out_k
    assign byte_w = prod_w[0][0] ^ prod_w[1][1] ^ prod_w[2][2] ^ prod_w[3][3];

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        byp_d       = byp_q;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        load_w      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_w = 1'b1;
                load_w     = bus.in_valid;
            end
            ST_COMPUTE: begin
                res_d = {byte_w, res_q[CW-1:BW]};
                col_d = {col_q[BW-1:0], col_q[CW-1:BW]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3 || byp_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_w = 1'b1;
                in_ready_w  = bus.out_ready;
                if (bus.out_ready) begin
                    load_w = bus.in_valid;
                    if (!bus.in_valid) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_w) begin
            col_d = bus.sh_col_in;
            byp_d = bus.bypass;
            cnt_d = '0;
            if (bus.bypass) begin
                res_d   = bus.sh_col_in;
                state_d = ST_DONE;
            end else begin
                state_d = ST_COMPUTE;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            byp_q   <= byp_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.sh_col_out = res_q;

endmodule
